// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path: FSM states, line levels, divider math.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Parallel-in request / serial-out status bundle between the sum-latch stage and the UART transmitter.
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_start;
  logic                 uart_txd;
  logic                 uart_tx_busy;
  logic                 tx_done;

  modport master (
    output tx_data, tx_start,
    input  uart_txd, uart_tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_start,
    output uart_txd, uart_tx_busy, tx_done
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Clock-to-baud divider: bit_tick_o on the last cycle of every bit, pre_tick_o one cycle earlier.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart_i,
  output logic bit_tick_o,
  output logic pre_tick_o
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_tick_o = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign pre_tick_o = (cnt_q == CNT_W'(CLKS_PER_BIT - 2));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart_i || bit_tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1/8N2 UART transmitter, LSB first, all outputs registered.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the payload.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  uart_tx_serializer_if.slave  bus
);
  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int IDX_W = $clog2(DATA_BITS);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 restart, bit_tick, pre_tick;
  logic                 accept;

  assign accept = (state_q == IDLE) && bus.tx_start;

  uart_baud_tick #(.CLKS_PER_BIT(CPB)) u_baud (
    .clk        (clk),
    .reset_n    (reset_n),
    .restart_i  (restart),
    .bit_tick_o (bit_tick),
    .pre_tick_o (pre_tick)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    parity_q <= 1'b0;
    else if (accept) parity_q <= ^bus.tx_data;
  end
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    restart = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = bus.tx_data;
          idx_d   = '0;
          restart = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_tick) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          idx_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // done is registered, so raise it one cycle ahead of the final stop cycle
        if (pre_tick && idx_q == IDX_W'(STOP_BITS - 1)) done_d = 1'b1;
        if (bit_tick) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Line level is driven from the upcoming state so txd changes on the same edge as the FSM.
    unique case (state_d)
      START:   txd_d = START_LEVEL;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_q;
`endif
      default: txd_d = IDLE_LEVEL;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      txd_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.uart_txd     = txd_q;
  assign bus.uart_tx_busy = busy_q;
  assign bus.tx_done      = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer at 16 clocks per bit; the frame model follows UART_TX_PARITY_EN.
module tb_uart_tx_serializer;
  localparam int C  = 16;
  localparam int DB = 8;
  localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int N = (1 + DB + P + SB) * C;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  uart_tx_serializer_if #(.DATA_BITS(DB)) bus ();

  uart_tx_serializer #(
    .CLK_FREQ  (16),
    .BAUD_RATE (1),
    .DATA_BITS (DB),
    .STOP_BITS (SB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level k cycles after the start edge: frame = start, payload LSB first, [parity], stops.
  function automatic logic model_level(input logic [7:0] d, input int k);
    int b;
    b = k / C;
    if (b == 0) return 1'b0;
    if (b <= DB) return d[b-1];
    if (P == 1 && b == DB + 1) return ^d;
    return 1'b1;
  endfunction

  task automatic check_idle(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      n_cmp++;
      if (bus.uart_txd !== 1'b1 || bus.uart_tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
        n_bad++;
        $display("FAIL %s idle cyc %0d: txd/busy/done got %b%b%b want 100", tag, i,
                 bus.uart_txd, bus.uart_tx_busy, bus.tx_done);
      end
      @(negedge clk);
    end
  endtask

  task automatic start_frame(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    @(negedge clk);
  endtask

  // Called on cycle 0 of a frame; scrambles tx_data while busy, optional extra start pulse or reset abort.
  task automatic expect_frame(input logic [7:0] d, input bit keep_start, input int pulse_at,
                              input logic [7:0] pulse_d, input int abort_at, input string tag);
    logic exp;
    for (int k = 0; k < N; k++) begin
      exp = model_level(d, k);
      n_cmp++;
      if (bus.uart_txd !== exp) begin
        n_bad++;
        $display("FAIL %s txd cyc %0d: got %b want %b", tag, k, bus.uart_txd, exp);
      end
      n_cmp++;
      if (bus.uart_tx_busy !== 1'b1) begin
        n_bad++;
        $display("FAIL %s busy cyc %0d: got %b want 1", tag, k, bus.uart_tx_busy);
      end
      n_cmp++;
      if (bus.tx_done !== (k == N - 1)) begin
        n_bad++;
        $display("FAIL %s done cyc %0d: got %b want %b", tag, k, bus.tx_done, (k == N - 1));
      end
      if (k == abort_at) begin
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.uart_txd !== 1'b1 || bus.uart_tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
          n_bad++;
          $display("FAIL %s abort: txd/busy/done got %b%b%b want 100", tag,
                   bus.uart_txd, bus.uart_tx_busy, bus.tx_done);
        end
        return;
      end
      if (k == 0) bus.tx_start = keep_start;
      if (pulse_at >= 0 && k == pulse_at) begin
        bus.tx_start = 1'b1;
        bus.tx_data  = pulse_d;
      end else begin
        if (pulse_at >= 0 && k == pulse_at + 1) bus.tx_start = 1'b0;
        bus.tx_data = 8'($urandom);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    #2;
    check_idle(5, "reset_hold");
    reset_n = 1'b1;
    check_idle(2 * C, "reset_release");
  endtask

  task automatic test_single();
    start_frame(8'h55);
    expect_frame(8'h55, 1'b0, -1, 8'h00, -1, "single55");
    check_idle(C, "single55_after");
  endtask

  task automatic test_ignore_busy();
    start_frame(8'hA3);
    expect_frame(8'hA3, 1'b0, 40, 8'hFF, -1, "ignoreA3");
    check_idle(N, "ignore_no_second");
  endtask

  task automatic test_back_to_back();
    start_frame(8'h00);
    expect_frame(8'h00, 1'b1, -1, 8'h00, -1, "b2b_first");
    bus.tx_data = 8'hFF;
    check_idle(1, "b2b_gap");
    expect_frame(8'hFF, 1'b0, -1, 8'h00, -1, "b2b_second");
    check_idle(C, "b2b_after");
  endtask

  task automatic test_reset_mid();
    start_frame(8'h0F);
    expect_frame(8'h0F, 1'b0, -1, 8'h00, 70, "abort0F");
    @(negedge clk);
    check_idle(2, "abort_held");
    reset_n = 1'b1;
    check_idle(3, "abort_release");
    start_frame(8'h81);
    expect_frame(8'h81, 1'b0, -1, 8'h00, -1, "after_abort81");
    check_idle(2, "after_abort_idle");
  endtask

  task automatic test_parity();
    start_frame(8'h07);
    expect_frame(8'h07, 1'b0, -1, 8'h00, -1, "par07");
    check_idle(1, "par07_idle");
    start_frame(8'h03);
    expect_frame(8'h03, 1'b0, -1, 8'h00, -1, "par03");
    check_idle(1, "par03_idle");
  endtask

  task automatic test_random();
    logic [7:0] d;
    int gap;
    for (int i = 0; i < 6; i++) begin
      gap = int'($urandom_range(0, 3));
      check_idle(gap, "rand_gap");
      d = 8'($urandom);
      start_frame(d);
      expect_frame(d, 1'b0, -1, 8'h00, -1, "rand");
    end
    check_idle(2, "rand_end");
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    reset_n      = 1'b0;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_parity();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
